// File: rtl/tico_ctsync_filt_pkg.sv
// tico_sync_pkg: shared constants and edge encoding for the control/status synchroniser.
package tico_sync_pkg;
  localparam int TICO_SYNC_MIN_STAGES = 2;
  typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} tico_edge_e;
endpackage

// File: rtl/tico_ctsync_filt_if.sv
// tico_ctsync_filt_if: threshold, async inputs and filtered level/edge outputs of the synchroniser.
interface tico_ctsync_filt_if #(parameter int NCH = 4, parameter int FILT_W = 4);
  logic [FILT_W-1:0] filt_thresh_i;
  logic [NCH-1:0]    data_i;
  logic [NCH-1:0]    data_o;
  logic [NCH-1:0]    rise_o;
  logic [NCH-1:0]    fall_o;
  modport master (output filt_thresh_i, data_i, input data_o, rise_o, fall_o);
  modport slave  (input filt_thresh_i, data_i, output data_o, rise_o, fall_o);
endinterface

// File: rtl/tico_ctsync_filt_ch.sv
// tico_ctsync_filt_ch: one channel -- flop chain, persistence counter and registered edge pulse.
module tico_ctsync_filt_ch
  import tico_sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILT_W  = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FILT_W-1:0] i_thresh,
  input  logic              i_data,
  output logic              o_data,
  output logic              o_rise,
  output logic              o_fall
);
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
  logic [FILT_W-1:0] r_cnt;
  logic              r_data;
  tico_edge_e        r_edge;
  logic              w_sy, w_mism, w_flip;
  assign w_sy   = r_sync[STAGES-1];
  assign w_mism = w_sy != r_data;
  assign w_flip = w_mism && (r_cnt >= i_thresh);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_cnt  <= '0;
      r_data <= RST_VAL;
      r_edge <= EDGE_NONE;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_data};
      r_cnt  <= (w_mism && !w_flip) ? r_cnt + 1'b1 : '0;
      r_data <= w_flip ? w_sy : r_data;
      r_edge <= !w_flip ? EDGE_NONE : w_sy ? EDGE_RISE : EDGE_FALL;
    end
  end
  assign o_data = r_data;
  assign o_rise = r_edge == EDGE_RISE;
  assign o_fall = r_edge == EDGE_FALL;
endmodule

// File: rtl/tico_ctsync_filt.sv
// tico_ctsync_filt: NCH independent synchroniser+glitch-filter channels sharing one threshold.
module tico_ctsync_filt
  import tico_sync_pkg::*;
#(
  parameter int             NCH     = 4,
  parameter int             STAGES  = 2,
  parameter int             FILT_W  = 4,
  parameter logic [NCH-1:0] RST_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  tico_ctsync_filt_if.slave bus
);
  if (STAGES < TICO_SYNC_MIN_STAGES || FILT_W < 1) begin : g_bad_param
    $error("tico_ctsync_filt: STAGES must be >= 2 and FILT_W >= 1");
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    tico_ctsync_filt_ch #(.STAGES(STAGES), .FILT_W(FILT_W), .RST_VAL(RST_VAL[c])) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_thresh (bus.filt_thresh_i),
      .i_data   (bus.data_i[c]),
      .o_data   (bus.data_o[c]),
      .o_rise   (bus.rise_o[c]),
      .o_fall   (bus.fall_o[c])
    );
  end
endmodule

// File: tb/tb_tico_ctsync_filt.sv
// tb_tico_ctsync_filt: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_tico_ctsync_filt;
  localparam int NCH = 4, STAGES = 2, FILT_W = 4;
  localparam logic [NCH-1:0] RST_VAL = 4'h0;
  logic clk = 1'b0, rst = 1'b1;
  int n_vec = 0, n_err = 0;
  tico_ctsync_filt_if #(.NCH(NCH), .FILT_W(FILT_W)) bus ();
  tico_ctsync_filt #(.NCH(NCH), .STAGES(STAGES), .FILT_W(FILT_W), .RST_VAL(RST_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  // model: input samples seen over the last STAGES edges, current level, mismatch run length
  logic [NCH-1:0] m_hist [STAGES];
  logic [NCH-1:0] m_data, m_rise, m_fall;
  int m_run [NCH];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic [NCH-1:0] d, input int t);
    logic sy;
    rst = r;
    bus.data_i = d;
    bus.filt_thresh_i = FILT_W'(t);
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      for (int k = 0; k < STAGES; k++) m_hist[k] = RST_VAL;
      m_data = RST_VAL;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        sy = m_hist[STAGES-1][c];
        if (sy == m_data[c]) m_run[c] = 0;
        else if (m_run[c] >= t) begin
          m_data[c] = sy;
          m_rise[c] = sy;
          m_fall[c] = !sy;
          m_run[c] = 0;
        end else m_run[c]++;
      end
      for (int k = STAGES - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = d;
    end
    @(posedge clk);
    #1;
    chk("data_o", {28'd0, bus.data_o}, {28'd0, m_data});
    chk("rise_o", {28'd0, bus.rise_o}, {28'd0, m_rise});
    chk("fall_o", {28'd0, bus.fall_o}, {28'd0, m_fall});
    if (bus.rise_o & bus.fall_o) chk("rise_and_fall", {28'd0, bus.rise_o & bus.fall_o}, 32'd0);
  endtask
  task automatic hold(input logic [NCH-1:0] d, input int t, input int n);
    for (int i = 0; i < n; i++) step(1'b0, d, t);
  endtask
  initial begin
    logic [NCH-1:0] d;
    int t;
    // 1: reset with inputs high, then release
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 0);
    chk("s1_rst_data", {28'd0, bus.data_o}, 32'h0);
    hold(4'hF, 0, 2);
    chk("s1_pre_data", {28'd0, bus.data_o}, 32'h0);
    hold(4'hF, 0, 1);
    chk("s1_data", {28'd0, bus.data_o}, 32'hF);
    chk("s1_rise", {28'd0, bus.rise_o}, 32'hF);
    hold(4'hF, 0, 1);
    chk("s1_rise_end", {28'd0, bus.rise_o}, 32'h0);
    // 2: glitch of 3 cycles rejected, 4 cycles accepted at T=3
    hold(4'h0, 0, 5);
    hold(4'h1, 3, 3);
    hold(4'h0, 3, 6);
    chk("s2_reject", {28'd0, bus.data_o}, 32'h0);
    hold(4'h1, 3, 4);
    hold(4'h0, 3, 2);
    chk("s2_accept", {28'd0, bus.data_o}, 32'h1);
    chk("s2_rise", {28'd0, bus.rise_o}, 32'h1);
    // 3: fall on channel 2 at T=0
    hold(4'h4, 0, 6);
    hold(4'h0, 0, 3);
    chk("s3_data", {28'd0, bus.data_o}, 32'h0);
    chk("s3_fall", {28'd0, bus.fall_o}, 32'h4);
    // 4: T=8 long count, then drop T to 2
    hold(4'h0, 0, 4);
    hold(4'h2, 8, 7);
    chk("s4_held", {28'd0, bus.data_o}, 32'h0);
    hold(4'h2, 2, 1);
    chk("s4_flip", {28'd0, bus.data_o}, 32'h2);
    chk("s4_rise", {28'd0, bus.rise_o}, 32'h2);
    // 5: simultaneous rise on ch1 and fall on ch3
    hold(4'h8, 0, 5);
    hold(4'h2, 0, 3);
    chk("s5_rise", {28'd0, bus.rise_o}, 32'h2);
    chk("s5_fall", {28'd0, bus.fall_o}, 32'h8);
    // 6: reset mid-count at T=10, then a full T+1 run needed
    hold(4'h0, 0, 5);
    hold(4'h1, 10, 7);
    step(1'b1, 4'h1, 10);
    chk("s6_rst_data", {28'd0, bus.data_o}, 32'h0);
    hold(4'h1, 10, 12);
    chk("s6_not_yet", {28'd0, bus.data_o}, 32'h0);
    hold(4'h1, 10, 1);
    chk("s6_flip", {28'd0, bus.data_o}, 32'h1);
    // random slow-changing traffic with live threshold changes and occasional reset
    d = 4'h0;
    t = 2;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
      if ($urandom_range(0, 40) == 0) t = $urandom_range(0, 15);
      step($urandom_range(0, 200) == 0, d, t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
